// File: rtl/accum_seq_pkg.sv
// Shared types and helpers for the accumulator tile sequencer.
// The mode codes must match the systolic datapath's decoding.
package accum_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FEED  = 3'd1,
    GAP   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } seq_state_e;

  // Datapath mode codes; 0/2 feed on flag bit 1, 1/3 feed on flag bit 0.
  localparam logic [1:0] MODE_0 = 2'd0;
  localparam logic [1:0] MODE_1 = 2'd1;
  localparam logic [1:0] MODE_2 = 2'd2;
  localparam logic [1:0] MODE_3 = 2'd3;

  function automatic logic fv_bit_sel(input logic [1:0] mode);
    return (mode == MODE_0) || (mode == MODE_2);
  endfunction

endpackage

// File: rtl/accum_tile_sequencer_if.sv
// Control bundle between the tile sequencer and its feeder/accumulator buffer.
// slave is the sequencer's view, master the driving side.
interface accum_tile_sequencer_if #(
  parameter int CNT_W   = 8,
  parameter int CHUNK_W = 8
);
  logic               start;
  logic [1:0]         mode;
  logic [CHUNK_W-1:0] num_chunks;
  logic [CNT_W-1:0]   chunk_len;
  logic               feed_ready;
  logic [1:0]         mode_FV_if;
  logic               store;
  logic               overwrite;
  logic [1:0]         mode_out;
  logic [CHUNK_W-1:0] chunk_idx;
  logic               busy;
  logic               done;

  modport master (
    output start, mode, num_chunks, chunk_len, feed_ready,
    input  mode_FV_if, store, overwrite, mode_out, chunk_idx, busy, done
  );

  modport slave (
    input  start, mode, num_chunks, chunk_len, feed_ready,
    output mode_FV_if, store, overwrite, mode_out, chunk_idx, busy, done
  );
endinterface

// File: rtl/accum_tile_sequencer.sv
// Walks one output tile across its K-chunks, driving feed-valid flags and
// the store/overwrite pair captured downstream on the flag's falling edge.
//
// state | meaning
// IDLE  | waiting for start, all outputs 0
// FEED  | active flag high, counting accepted beats
// GAP   | one cycle with flag low; downstream captures store/overwrite
// DRAIN | datapath drain wait, beat counter reused as drain counter
// DONE  | one-cycle completion pulse
module accum_tile_sequencer
  import accum_seq_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int CHUNK_W      = 8,
  parameter int DRAIN_CYCLES = 16
) (
  input logic                   clk,
  input logic                   rst,
  accum_tile_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

  seq_state_e         state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [CNT_W-1:0]   len_r, len_nxt;
  logic [CHUNK_W-1:0] idx_r, idx_nxt;
  logic [CHUNK_W-1:0] nch_r, nch_nxt;
  logic [1:0]         mode_r, mode_nxt;
  logic               store_r, store_nxt;
  logic               ovw_r, ovw_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      len_r   <= '0;
      idx_r   <= '0;
      nch_r   <= '0;
      mode_r  <= '0;
      store_r <= 1'b0;
      ovw_r   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      len_r   <= len_nxt;
      idx_r   <= idx_nxt;
      nch_r   <= nch_nxt;
      mode_r  <= mode_nxt;
      store_r <= store_nxt;
      ovw_r   <= ovw_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    len_nxt   = len_r;
    idx_nxt   = idx_r;
    nch_nxt   = nch_r;
    mode_nxt  = mode_r;
    store_nxt = store_r;
    ovw_nxt   = ovw_r;
    case (state)
      IDLE: begin
        if (bus.start) begin
          mode_nxt  = bus.mode;
          nch_nxt   = (bus.num_chunks == '0) ? CHUNK_W'(1) : bus.num_chunks;
          len_nxt   = (bus.chunk_len == '0) ? CNT_W'(1) : bus.chunk_len;
          idx_nxt   = '0;
          cnt_nxt   = '0;
          ovw_nxt   = 1'b1;
          store_nxt = (nch_nxt == CHUNK_W'(1));
          state_nxt = FEED;
        end
      end
      FEED: begin
        if (bus.feed_ready) begin
          if (cnt == len_r - CNT_W'(1)) state_nxt = GAP;
          else                          cnt_nxt   = cnt + CNT_W'(1);
        end
      end
      GAP: begin
        cnt_nxt = '0;
        if (idx_r == nch_r - CHUNK_W'(1)) begin
          state_nxt = DRAIN;
        end else begin
          idx_nxt   = idx_r + CHUNK_W'(1);
          ovw_nxt   = 1'b0;
          store_nxt = (idx_nxt == nch_r - CHUNK_W'(1));
          state_nxt = FEED;
        end
      end
      DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          store_nxt = 1'b0;
          ovw_nxt   = 1'b0;
          idx_nxt   = '0;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        mode_nxt  = '0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode registered state only; no input reaches them combinationally.
  assign bus.mode_FV_if = (state == FEED) ? (fv_bit_sel(mode_r) ? 2'b10 : 2'b01) : 2'b00;
  assign bus.store      = store_r;
  assign bus.overwrite  = ovw_r;
  assign bus.mode_out   = mode_r;
  assign bus.chunk_idx  = idx_r;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);

endmodule

// File: tb/tb_accum_tile_sequencer.sv
// Bench for accum_tile_sequencer: per-cycle traces built from the run rules
// (chunks, beats, stalls, drain) and compared against the DUT every cycle.
module tb_accum_tile_sequencer;

  localparam int CNT_W   = 8;
  localparam int CHUNK_W = 8;
  localparam int DRAIN   = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  accum_tile_sequencer_if #(.CNT_W(CNT_W), .CHUNK_W(CHUNK_W)) bus ();

  accum_tile_sequencer #(
    .CNT_W(CNT_W), .CHUNK_W(CHUNK_W), .DRAIN_CYCLES(DRAIN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [1:0] fv;
    logic       store;
    logic       ovw;
    logic [1:0] mode_out;
    logic [7:0] idx;
    logic       busy;
    logic       done;
  } out_t;

  typedef struct packed {
    logic       s;
    logic [1:0] m;
    logic [7:0] n;
    logic [7:0] l;
    logic       r;
  } in_t;

  typedef struct {
    logic [1:0] m;
    int         n;
    int         l;
    int         stall;
    bit         noise;
    int         exp_done;
  } vec_t;

  in_t  in_q[$];
  out_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   done_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic drive(input in_t iv);
    bus.start      = iv.s;
    bus.mode       = iv.m;
    bus.num_chunks = iv.n;
    bus.chunk_len  = iv.l;
    bus.feed_ready = iv.r;
  endtask

  function automatic out_t sample();
    out_t o;
    o = {bus.mode_FV_if, bus.store, bus.overwrite, bus.mode_out,
         bus.chunk_idx, bus.busy, bus.done};
    return o;
  endfunction

  function automatic in_t busy_in(input bit noise, input logic [1:0] m, input int n, input int l);
    in_t iv;
    iv.s = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    iv.m = noise ? 2'($urandom_range(0, 3)) : m;
    iv.n = noise ? 8'($urandom_range(0, 255)) : 8'(n);
    iv.l = noise ? 8'($urandom_range(0, 255)) : 8'(l);
    iv.r = 1'($urandom_range(0, 1));
    return iv;
  endfunction

  // Reference: lays out the expected cycle-by-cycle picture of one run.
  task automatic build_run(input logic [1:0] m, input int n, input int l,
                           input int stall, input bit noise);
    int ne, le, beats, fc;
    logic [1:0] fv;
    in_t  iv;
    out_t ov;
    ne = (n == 0) ? 1 : n;
    le = (l == 0) ? 1 : l;
    fv = (m == 2'd0 || m == 2'd2) ? 2'b10 : 2'b01;
    iv.s = 1'b1; iv.m = m; iv.n = 8'(n); iv.l = 8'(l); iv.r = 1'b0;
    in_q.push_back(iv);
    exp_q.push_back('0);
    for (int c = 0; c < ne; c++) begin
      beats = 0;
      fc = 0;
      while (beats < le) begin
        iv = busy_in(noise, m, n, l);
        case (stall)
          0:       iv.r = 1'b1;
          1:       iv.r = ($urandom_range(0, 3) != 0);
          default: iv.r = !(fc == 1 || fc == 2);
        endcase
        ov = '{fv, (c == ne - 1), (c == 0), m, 8'(c), 1'b1, 1'b0};
        in_q.push_back(iv);
        exp_q.push_back(ov);
        if (iv.r) beats++;
        fc++;
      end
      ov.fv = 2'b00;
      in_q.push_back(busy_in(noise, m, n, l));
      exp_q.push_back(ov);
    end
    for (int d = 0; d < DRAIN; d++) begin
      in_q.push_back(busy_in(noise, m, n, l));
      exp_q.push_back(ov);
    end
    // A start presented in the DONE cycle must not launch a new run.
    iv = busy_in(noise, m, n, l);
    iv.s = 1'b1;
    ov = '0; ov.mode_out = m; ov.busy = 1'b1; ov.done = 1'b1;
    in_q.push_back(iv);
    exp_q.push_back(ov);
    iv = busy_in(1'b0, m, n, l);
    in_q.push_back(iv);
    exp_q.push_back('0);
  endtask

  task automatic run_trace(input int ncyc);
    out_t o;
    int lim;
    lim = (ncyc < 0 || ncyc > in_q.size()) ? in_q.size() : ncyc;
    done_cyc = -1;
    for (int i = 0; i < lim; i++) begin
      drive(in_q[i]);
      @(negedge clk);
      o = sample();
      if (o.done === 1'b1 && done_cyc < 0) done_cyc = i;
      check($sformatf("trace cyc %0d", i), 32'(o), 32'(exp_q[i]));
      @(posedge clk);
      #1;
    end
    in_q.delete();
    exp_q.delete();
  endtask

  vec_t tbl[5];
  in_t  idle_in;

  initial begin
    tbl[0] = '{2'd0, 1, 4, 0, 1'b0, 22};
    tbl[1] = '{2'd1, 3, 2, 0, 1'b1, 26};
    tbl[2] = '{2'd0, 1, 3, 2, 1'b0, 23};
    tbl[3] = '{2'd2, 0, 0, 0, 1'b0, 19};
    tbl[4] = '{2'd3, 2, 5, 1, 1'b1, -1};

    idle_in = '0;
    drive(idle_in);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset outputs", 32'(sample()), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int t = 0; t < 5; t++) begin
      build_run(tbl[t].m, tbl[t].n, tbl[t].l, tbl[t].stall, tbl[t].noise);
      run_trace(-1);
      if (tbl[t].exp_done >= 0)
        check($sformatf("done cycle vec %0d", t), 32'(done_cyc), 32'(tbl[t].exp_done));
    end

    // Reset in the middle of chunk 1's FEED, then a clean restart.
    build_run(2'd2, 3, 4, 0, 1'b0);
    run_trace(8);
    #2 rst = 1'b0;
    #1 check("async reset outputs", 32'(sample()), 32'd0);
    drive(idle_in);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    build_run(2'd1, 2, 2, 0, 1'b1);
    run_trace(-1);
    check("restart done cycle", 32'(done_cyc), 32'(2 * 3 + 1 + DRAIN));

    for (int k = 0; k < 20; k++) begin
      build_run(2'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                int'($urandom_range(0, 5)), 1, 1'b1);
      run_trace(-1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
